// File: rtl/vram_dma.sv
// Byte-wide copy engine from a source memory into GPU VRAM, writing only during vblank.
// Optional constant-fill mode is compiled in with the VRAM_DMA_FILL_EN macro.
`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 13
`endif

module vram_dma #(
  parameter int unsigned ADDR_W = `VRAM_ADDR_WIDTH,
  parameter int unsigned SRC_W  = 16,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clk_12_5875,
  input  logic              rst,
  input  logic              start,
  input  logic [SRC_W-1:0]  src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [LEN_W-1:0]  length,
  input  logic              vblank,
`ifdef VRAM_DMA_FILL_EN
  input  logic              fill,
  input  logic [7:0]        fill_value,
`endif
  output logic [SRC_W-1:0]  src_addr,
  input  logic [7:0]        src_data,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] address,
  output logic              cs,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic [SRC_W-1:0]  src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  written;
  logic              rd_valid;
  logic              pend_valid;
  logic [7:0]        pend_data;
  logic [7:0]        data_q;
  logic [ADDR_W-1:0] addr_q;

  logic              accept;
  logic              issue;
  logic              wr;
  logic              pend_load;
  logic [7:0]        wr_data;
  logic [ADDR_W-1:0] wr_addr;

  logic              fill_mode;
  logic [7:0]        fill_byte;

`ifdef VRAM_DMA_FILL_EN
  logic              fill_q;
  logic [7:0]        fill_val_q;

  // Fill settings are captured with the rest of the transfer parameters
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      fill_q     <= 1'b0;
      fill_val_q <= 8'h00;
    end else if (accept) begin
      fill_q     <= fill;
      fill_val_q <= fill_value;
    end
  end

  assign fill_mode = fill_q;
  assign fill_byte = fill_val_q;
`else
  assign fill_mode = 1'b0;
  assign fill_byte = 8'h00;
`endif

  // State register
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, read issue and write decisions for the current cycle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    wr        = 1'b0;
    pend_load = 1'b0;
    wr_data   = pend_data;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = FINISH;
          end
        end
      end
      RUN, DRAIN: begin
        if (fill_mode) begin
          wr      = (state == RUN) && vblank && (written < len_q);
          wr_data = fill_byte;
        end else begin
          issue = (state == RUN) && vblank && !pend_valid && (issued < len_q);
          // A returning byte that cannot be written now parks in the pending slot
          if (pend_valid) begin
            wr      = vblank;
            wr_data = pend_data;
          end else if (rd_valid) begin
            wr        = vblank;
            wr_data   = src_data;
            pend_load = !vblank;
          end
        end
        if (wr && (written == len_q - LEN_W'(1)))
          state_nxt = FINISH;
        else if (issue && (issued == len_q - LEN_W'(1)))
          state_nxt = DRAIN;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_addr  = dst_q + ADDR_W'(written);
  assign src_addr = fill_mode ? '0 : src_q + SRC_W'(issued);
  assign cs       = wr;
  assign data     = wr ? wr_data : data_q;
  assign address  = wr ? wr_addr : addr_q;

  // Datapath: transfer parameters, counters, pending byte and held write port
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      issued     <= '0;
      written    <= '0;
      rd_valid   <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
      data_q     <= 8'h00;
      addr_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      busy     <= (state_nxt != IDLE);
      done     <= (state_nxt == FINISH);
      rd_valid <= issue;
      if (accept) begin
        src_q   <= src_base;
        dst_q   <= dst_base;
        len_q   <= length;
        issued  <= '0;
        written <= '0;
      end
      if (issue) issued <= issued + LEN_W'(1);
      if (wr) begin
        written <= written + LEN_W'(1);
        data_q  <= wr_data;
        addr_q  <= wr_addr;
      end
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_data  <= src_data;
      end else if (pend_valid && wr) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
